uart_rx_fifo: RTL

Serial-line receiver for the far end of the core's UART `tx_bit` link. It deserializes 8N1 frames (LSB first) from an asynchronous serial input into bytes and buffers them in a small FIFO. Downstream logic (host bridge, debug monitor or testbench harness) drains the FIFO through a valid/ready handshake. Sticky flags report framing errors and overflow.

---
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a small circular FIFO drained by valid/ready.
// Sticky frame_err/overflow flags; all state on clock, async active-high reset.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_bit,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overflow,
  input  logic                     clear_flags
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_sync;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sr_q, sr_d;
  logic             push;
  logic             ferr_set;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;

  assign sync1_d = rx_bit;
  assign sync2_d = sync1_q;
  assign rx_sync = sync2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_sync) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          sr_d  = {rx_sync, sr_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        // Leaving at mid-stop gives half a bit of slack to catch the next start edge.
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_sync) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_sync) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = (count_q != '0) && rx_ready;
    push_ok  = push && ((count_q < FULL_OCC) || pop);
    ovf_set  = push && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + OCC_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - OCC_W'(1);
    end
    // Head register tracks the entry at the read pointer after this cycle's update.
    rx_data_d = rx_data_q;
    if (pop) begin
      if (count_q > OCC_W'(1)) begin
        rx_data_d = mem_q[rd_ptr_q + PTR_W'(1)];
      end else if (push_ok) begin
        rx_data_d = sr_q;
      end
    end else if (push_ok && (count_q == '0)) begin
      rx_data_d = sr_q;
    end
    frame_err_d = ferr_set ? 1'b1 : (clear_flags ? 1'b0 : frame_err_q);
    overflow_d  = ovf_set  ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      sr_q        <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= sr_q;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = (count_q != '0);
  assign rx_count  = count_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
